gcd_ctrl: RTL and testbench

//  FSM controller sequencing the 7-bit subtractive Euclidean GCD datapath (A/B regs, input muxes, subtractor, comparator).

---
 rtl/gcd_ctrl.sv | 153 +++++++++++++++
 tb/tb_gcd_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_ctrl.sv
// gcd_ctrl
//   Sequencer for a 7-bit subtractive Euclidean GCD datapath. The datapath
//   holds operand registers A and B, their input muxes, a subtractor and a
//   comparator.
//   After loading the operands, the controller alternates between two kinds of
//   step until B == 0:
//     - CHECK, followed by SUB  (A <= A-B), or
//     - CHECK, followed by SWAP (A <= B, B <= A).
//   The result is left in A.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous reset, active-high
//   start     request a new computation (only honoured in IDLE)
//   abort     synchronous cancel, returns to IDLE without a done pulse
//   a_lt_b    datapath status: A < B (unsigned)
//   b_eq_0    datapath status: B == 0
//   a_sel     A mux:        1 = external operand, 0 = feedback t1
//   t1_sel    feedback mux: 0 = A-B, 1 = B
//   b_sel     B mux:        1 = external operand, 0 = A
//   a_ld      A register load enable
//   b_ld      B register load enable
//   busy      high in LOAD/CHECK/SUB/SWAP
//   done      one-cycle completion pulse
//   err       sticky runaway flag, cleared by the next accepted start
//   iter_cnt  SUB+SWAP steps in the current/last run
//
// State table
//   state   | meaning
//   IDLE    | waiting for start, all strobes low
//   LOAD    | capture external operands into A and B
//   CHECK   | evaluate datapath status, pick next step
//   SUB     | A <= A - B
//   SWAP    | A <= B, B <= A on the same edge
//   DONE    | one-cycle done pulse, then back to IDLE
module gcd_ctrl #(
  parameter int CNT_W    = 8,
  parameter int MAX_ITER = 255   // must not exceed 2**CNT_W-1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             a_lt_b,
  input  logic             b_eq_0,
  output logic             a_sel,
  output logic             t1_sel,
  output logic             b_sel,
  output logic             a_ld,
  output logic             b_ld,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] iter_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_SUB,
    S_SWAP,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] ITER_LIMIT = CNT_W'(MAX_ITER);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] iter_nxt;
  logic             err_nxt;

  // Strobe decode, ordered {a_sel, t1_sel, b_sel, a_ld, b_ld, busy, done}.
  // Selects belonging to a register that is not being loaded are held at 0.
  function automatic logic [6:0] strobes(input state_t s);
    logic [6:0] v;
    v = 7'b0;
    case (s)
      S_LOAD:  v = 7'b1011110;
      S_CHECK: v = 7'b0000010;
      S_SUB:   v = 7'b0001010;
      S_SWAP:  v = 7'b0101110;
      S_DONE:  v = 7'b0000001;
      default: v = 7'b0;
    endcase
    return v;
  endfunction

  always_comb begin
    state_nxt = state;
    iter_nxt  = iter_cnt;
    err_nxt   = err;
    if (abort) begin
      // Cancel: counter and error flag keep their values for inspection.
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state_nxt = S_LOAD;
            iter_nxt  = '0;
            err_nxt   = 1'b0;
          end
        end
        S_LOAD:  state_nxt = S_CHECK;
        S_CHECK: begin
          if (b_eq_0) begin
            state_nxt = S_DONE;
          end else if (iter_cnt == ITER_LIMIT) begin
            // Runaway guard: stop before another increment could wrap.
            state_nxt = S_DONE;
            err_nxt   = 1'b1;
          end else if (a_lt_b) begin
            state_nxt = S_SWAP;
          end else begin
            state_nxt = S_SUB;
          end
        end
        S_SUB, S_SWAP: begin
          state_nxt = S_CHECK;
          if (iter_cnt != ITER_LIMIT) begin
            iter_nxt = iter_cnt + CNT_W'(1);
          end
        end
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next-state decode, so they always match
  // the state currently held (Moore behaviour without a decode delay).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      iter_cnt <= '0;
      err      <= 1'b0;
      a_sel    <= 1'b0;
      t1_sel   <= 1'b0;
      b_sel    <= 1'b0;
      a_ld     <= 1'b0;
      b_ld     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      iter_cnt <= iter_nxt;
      err      <= err_nxt;
      {a_sel, t1_sel, b_sel, a_ld, b_ld, busy, done} <= strobes(state_nxt);
    end
  end

endmodule

// File: tb/tb_gcd_ctrl.sv
// tb_gcd_ctrl
//   Two controller instances (MAX_ITER 255 and 4), each driving a small
//   behavioural A/B datapath. A step-level GCD model predicts the per-cycle
//   strobes, iter_cnt and err, and a negedge process compares against them.
module tb_gcd_ctrl;

  typedef struct packed {
    logic [6:0] ctl;
    logic [7:0] it;
    logic       er;
  } exp_t;

  localparam logic [6:0] C_IDLE  = 7'b0000000;
  localparam logic [6:0] C_LOAD  = 7'b1011110;
  localparam logic [6:0] C_CHECK = 7'b0000010;
  localparam logic [6:0] C_SUB   = 7'b0001010;
  localparam logic [6:0] C_SWAP  = 7'b0101110;
  localparam logic [6:0] C_DONE  = 7'b0000001;

  logic       clk = 1'b0;
  logic       rst_v   [2];
  logic       start_v [2];
  logic       abort_v [2];
  logic [6:0] opa_v   [2];
  logic [6:0] opb_v   [2];
  logic [6:0] ctl_v   [2];
  logic [7:0] it_v    [2];
  logic       er_v    [2];
  logic [6:0] ra_v    [2];

  int total = 0;
  int bad   = 0;

  exp_t seq[$];
  exp_t q0[$];
  exp_t q1[$];
  logic [7:0] cur_it [2];
  logic       cur_er [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gi
    logic       a_sel, t1_sel, b_sel, a_ld, b_ld, busy, done, err;
    logic [7:0] iter_cnt;
    logic [6:0] ra = 7'd0;
    logic [6:0] rb = 7'd0;

    gcd_ctrl #(.CNT_W(8), .MAX_ITER(g == 0 ? 255 : 4)) dut (
      .clk      (clk),
      .rst      (rst_v[g]),
      .start    (start_v[g]),
      .abort    (abort_v[g]),
      .a_lt_b   (ra < rb),
      .b_eq_0   (rb == 7'd0),
      .a_sel    (a_sel),
      .t1_sel   (t1_sel),
      .b_sel    (b_sel),
      .a_ld     (a_ld),
      .b_ld     (b_ld),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .iter_cnt (iter_cnt)
    );

    always @(posedge clk) begin
      if (a_ld) ra <= a_sel ? opa_v[g] : (t1_sel ? rb : ra - rb);
      if (b_ld) rb <= b_sel ? opb_v[g] : ra;
    end

    assign ctl_v[g] = {a_sel, t1_sel, b_sel, a_ld, b_ld, busy, done};
    assign it_v[g]  = iter_cnt;
    assign er_v[g]  = err;
    assign ra_v[g]  = ra;
  end

  function automatic void check(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endfunction

  function automatic void cmp(input int inst, input exp_t e);
    check($sformatf("ctl%0d", inst), {9'd0, ctl_v[inst]}, {9'd0, e.ctl});
    check($sformatf("iter%0d", inst), {8'd0, it_v[inst]}, {8'd0, e.it});
    check($sformatf("err%0d", inst), {15'd0, er_v[inst]}, {15'd0, e.er});
  endfunction

  always @(negedge clk) begin
    if (q0.size() > 0) cmp(0, q0.pop_front());
    if (q1.size() > 0) cmp(1, q1.pop_front());
  end

  function automatic void push(input logic [6:0] c, input int it, input logic er);
    exp_t e;
    e.ctl = c;
    e.it  = 8'(it);
    e.er  = er;
    seq.push_back(e);
  endfunction

  // Euclid by repeated subtraction, one entry per expected clock cycle,
  // starting with the IDLE cycle in which start is presented.
  task automatic build(input int inst, input int a, input int b, input int mx,
                       output int res, output int n, output bit e);
    int x, y, t;
    x = a; y = b; n = 0; e = 0;
    seq.delete();
    push(C_IDLE, int'(cur_it[inst]), cur_er[inst]);
    push(C_LOAD, 0, 1'b0);
    push(C_CHECK, 0, 1'b0);
    while (y != 0) begin
      if (n == mx) begin
        e = 1;
        break;
      end
      if (x < y) begin
        t = x; x = y; y = t;
        push(C_SWAP, n, 1'b0);
      end else begin
        x = x - y;
        push(C_SUB, n, 1'b0);
      end
      n++;
      push(C_CHECK, n, 1'b0);
    end
    push(C_DONE, n, e);
    push(C_IDLE, n, e);
    res = x;
  endtask

  task automatic run_op(input int inst, input int a, input int b, input int abort_at,
                        input int rst_at, input bit hold, input bit pulse);
    int   res, n, len;
    bit   e;
    exp_t last;
    build(inst, a, b, inst == 0 ? 255 : 4, res, n, e);
    if (abort_at >= 0) begin
      last = seq[abort_at];
      while (seq.size() > abort_at + 1) void'(seq.pop_back());
      push(C_IDLE, int'(last.it), last.er);
      push(C_IDLE, int'(last.it), last.er);
    end
    if (rst_at >= 0) begin
      while (seq.size() > rst_at) void'(seq.pop_back());
      push(C_IDLE, 0, 1'b0);
      push(C_IDLE, 0, 1'b0);
    end
    opa_v[inst] = 7'(a);
    opb_v[inst] = 7'(b);
    len = seq.size();
    foreach (seq[k]) begin
      if (inst == 0) q0.push_back(seq[k]);
      else           q1.push_back(seq[k]);
    end
    for (int i = 0; i < len; i++) begin
      rst_v[inst]   = 1'b0;
      start_v[inst] = (i == 0) || (hold && i < len - 1) || (pulse && i == 4);
      abort_v[inst] = (i == abort_at);
      if (i == rst_at) begin
        #2 rst_v[inst] = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    rst_v[inst]   = 1'b0;
    start_v[inst] = 1'b0;
    abort_v[inst] = 1'b0;
    cur_it[inst] = seq[len-1].it;
    cur_er[inst] = seq[len-1].er;
    if (abort_at < 0 && rst_at < 0 && !e)
      check($sformatf("result%0d", inst), {9'd0, ra_v[inst]}, 16'(res));
  endtask

  initial begin
    int  res, n;
    bit  e;
    for (int g = 0; g < 2; g++) begin
      rst_v[g] = 1'b1; start_v[g] = 1'b0; abort_v[g] = 1'b0;
      opa_v[g] = 7'd0; opb_v[g] = 7'd0;
      cur_it[g] = 8'd0; cur_er[g] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      check("rst_ctl", {9'd0, ctl_v[g]}, 16'd0);
      check("rst_iter", {8'd0, it_v[g]}, 16'd0);
      check("rst_err", {15'd0, er_v[g]}, 16'd0);
    end
    rst_v[0] = 1'b0; rst_v[1] = 1'b0;
    @(posedge clk);
    #1;

    // Hand-derived anchors for the model.
    build(0, 12, 8, 255, res, n, e);
    check("pin12_8_res", 16'(res), 16'd4);
    check("pin12_8_n", 16'(n), 16'd5);
    check("pin12_8_done_cycle", {9'd0, seq[13].ctl}, {9'd0, C_DONE});
    check("pin12_8_len", 16'(seq.size()), 16'd15);
    build(0, 127, 1, 255, res, n, e);
    check("pin127_1_res", 16'(res), 16'd1);
    check("pin127_1_n", 16'(n), 16'd128);
    build(1, 100, 3, 4, res, n, e);
    check("pin100_3_err", 16'(e), 16'd1);
    check("pin100_3_n", 16'(n), 16'd4);
    build(0, 9, 6, 255, res, n, e);
    check("pin9_6_res", 16'(res), 16'd3);
    check("pin9_6_n", 16'(n), 16'd5);
    build(0, 0, 0, 255, res, n, e);
    check("pin0_0_len", 16'(seq.size()), 16'd5);

    run_op(0, 12, 8, -1, -1, 1'b0, 1'b0);
    run_op(0, 127, 1, -1, -1, 1'b0, 1'b0);
    run_op(0, 0, 0, -1, -1, 1'b0, 1'b0);
    run_op(0, 45, 0, -1, -1, 1'b0, 1'b0);
    run_op(0, 0, 77, -1, -1, 1'b0, 1'b0);
    run_op(1, 100, 3, -1, -1, 1'b0, 1'b0);
    run_op(1, 5, 5, -1, -1, 1'b0, 1'b0);
    run_op(0, 12, 8, 9, -1, 1'b0, 1'b0);
    run_op(0, 9, 6, -1, -1, 1'b0, 1'b0);
    run_op(0, 12, 8, -1, -1, 1'b1, 1'b1);
    run_op(0, 35, 21, -1, -1, 1'b0, 1'b1);
    run_op(0, 12, 8, -1, 5, 1'b0, 1'b0);
    run_op(0, 21, 14, -1, -1, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
